// File: rtl/div_seq.sv
// Restoring unsigned divider, one quotient bit per clock, start/done handshake.
// state  | meaning
// S_IDLE | waiting for go; last result held on quotient/remainder
// S_BUSY | one restoring step per edge, WIDTH steps in total
// S_DONE | one-cycle done pulse; go here starts the next op back-to-back
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_step;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b1;
        done       = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    accept     = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                ready = 1'b0;
                if (count == LAST_CNT) begin
                    last_step  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (go) begin
                    accept     = 1'b1;
                    state_next = S_BUSY;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The borrow out of the WIDTH+1 bit subtract is the inverted compare result.
    always_comb begin
        r_shift = {rem, dvd[WIDTH-1]};
        diff    = r_shift - {1'b0, dvs};
        qbit    = ~diff[WIDTH];
        r_next  = qbit ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_next  = {dvd[WIDTH-2:0], qbit};
    end

    // The dividend register shifts out dividend bits and shifts in quotient bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            count <= '0;
            dvd   <= left;
            dvs   <= right;
            rem   <= '0;
        end else if (state == S_BUSY) begin
            count <= count + 1'b1;
            dvd   <= q_next;
            rem   <= r_next;
            if (last_step) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq at WIDTH=8 (per-cycle model) and WIDTH=32 (sweep).
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go8, ready8, done8;
    logic [7:0]  left8, right8, q8, r8;
    logic        go32, ready32, done32;
    logic [31:0] left32, right32, q32, r32;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done8 === 1'b1) done_cnt <= done_cnt + 1;

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .go(go8), .left(left8), .right(right8),
        .ready(ready8), .done(done8), .quotient(q8), .remainder(r8)
    );

    div_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .go(go32), .left(left32), .right(right32),
        .ready(ready32), .done(done32), .quotient(q32), .remainder(r32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: an accepted op is busy for 8 edges, then its arithmetic result appears with done.
    int         m_cnt;
    logic [7:0] m_q, m_r, p_q, p_r;
    logic       m_done;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  = 0;
            m_q    = 8'd0;
            m_r    = 8'd0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_q    = p_q;
                    m_r    = p_r;
                    m_done = 1'b1;
                end
            end else if (go8) begin
                m_cnt = 8;
                if (right8 == 8'd0) begin
                    p_q = 8'hFF;
                    p_r = left8;
                end else begin
                    p_q = left8 / right8;
                    p_r = left8 % right8;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n === 1'b1) begin
            check("model_ready", ready8, m_cnt == 0);
            check("model_done", done8, m_done);
            check("model_quotient", q8, m_q);
            check("model_remainder", r8, m_r);
        end
    end

    task automatic wait_done(input bit wide, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((wide ? done32 : done8) === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 40 cycles, expected a done pulse");
        end
    endtask

    task automatic start8(input logic [7:0] l, input logic [7:0] r, output int acc);
        @(negedge clk);
        go8 = 1'b1; left8 = l; right8 = r;
        @(posedge clk);
        #1;
        acc = cyc;
        check("ready_low_busy", ready8, 1'b0);
    endtask

    logic [7:0] tl [6] = '{8'd200, 8'd37, 8'd255, 8'd5, 8'd128, 8'd255};
    logic [7:0] tr [6] = '{8'd7,   8'd0,  8'd1,   8'd9, 8'd128, 8'd255};
    logic [7:0] tq [6] = '{8'd28,  8'd255, 8'd255, 8'd0, 8'd1,  8'd1};
    logic [7:0] tm [6] = '{8'd4,   8'd37, 8'd0,   8'd5, 8'd0,   8'd0};

    initial begin
        int acc, t1, t2, d0;
        logic [31:0] eq, er;
        reset_n = 1'b0;
        go8 = 1'b0; left8 = '0; right8 = '0;
        go32 = 1'b0; left32 = '0; right32 = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", ready8, 1'b1);
        check("reset_done", done8, 1'b0);
        check("reset_quotient", q8, 8'd0);
        check("reset_remainder", r8, 8'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start8(tl[i], tr[i], acc);
            go8 = 1'b0;
            wait_done(1'b0, t1);
            check("latency", t1 - acc, 8);
            check("directed_quotient", q8, tq[i]);
            check("directed_remainder", r8, tm[i]);
            repeat (2) @(negedge clk);
        end

        // go during BUSY is ignored; operand changes after accept have no effect
        start8(8'd200, 8'd7, acc);
        go8 = 1'b0; left8 = 8'd9; right8 = 8'd2;
        repeat (3) @(negedge clk);
        go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0; left8 = 8'd55; right8 = 8'd3;
        wait_done(1'b0, t1);
        check("ignored_go_latency", t1 - acc, 8);
        check("ignored_go_quotient", q8, 8'd28);
        check("ignored_go_remainder", r8, 8'd4);
        @(posedge clk);
        #1;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        check("ignored_go_single_done", done_cnt, d0);

        // back-to-back with go held high
        start8(8'd100, 8'd3, acc);
        left8 = 8'd250; right8 = 8'd16;
        wait_done(1'b0, t1);
        check("b2b_first_latency", t1 - acc, 8);
        check("b2b_first_quotient", q8, 8'd33);
        check("b2b_first_remainder", r8, 8'd1);
        @(negedge clk);
        check("b2b_hold_quotient", q8, 8'd33);
        check("b2b_hold_remainder", r8, 8'd1);
        wait_done(1'b0, t2);
        go8 = 1'b0;
        check("b2b_done_spacing", t2 - t1, 9);
        check("b2b_second_quotient", q8, 8'd15);
        check("b2b_second_remainder", r8, 8'd10);
        repeat (3) @(negedge clk);

        // asynchronous reset in the middle of an op
        start8(8'd200, 8'd7, acc);
        go8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_ready", ready8, 1'b1);
        check("midreset_done", done8, 1'b0);
        check("midreset_quotient", q8, 8'd0);
        check("midreset_remainder", r8, 8'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        check("midreset_no_done", done_cnt, d0);
        check("midreset_ready_after", ready8, 1'b1);

        // WIDTH=32 random sweep against plain arithmetic
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            go32   = 1'b1;
            left32 = $urandom;
            case ($urandom_range(0, 3))
                0:       right32 = $urandom_range(0, 15);
                1:       right32 = $urandom;
                2:       right32 = $urandom >> $urandom_range(0, 31);
                default: right32 = left32;
            endcase
            if (right32 == 32'd0) begin
                eq = 32'hFFFF_FFFF;
                er = left32;
            end else begin
                eq = left32 / right32;
                er = left32 % right32;
            end
            @(posedge clk);
            #1;
            acc  = cyc;
            go32 = 1'b0;
            left32  = $urandom;
            right32 = $urandom;
            wait_done(1'b1, t1);
            check("sweep_latency", t1 - acc, 32);
            check("sweep_quotient", q32, eq);
            check("sweep_remainder", r32, er);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
